// File: rtl/alu_pkg.sv
// Shared ALU encodings and saturation limits for the 16-bit add pipeline.
package alu_pkg;

   typedef enum logic [1:0] {
      OP_ADD    = 2'b00,
      OP_SUB    = 2'b01,
      OP_PADDSB = 2'b10,
      OP_RSVD   = 2'b11
   } op_e;

   localparam logic [15:0] SAT_POS16 = 16'h7FFF;
   localparam logic [15:0] SAT_NEG16 = 16'h8000;
   localparam logic [3:0]  SAT_POS4  = 4'h7;
   localparam logic [3:0]  SAT_NEG4  = 4'h8;

endpackage

// File: rtl/carry_look_ahead.sv
// 4-bit carry-lookahead adder slice; with pad set it becomes an isolated
// signed nibble adder (carry-in ignored) that saturates to 0x7 / 0x8.
module carry_look_ahead
   import alu_pkg::*;
(
   input  logic [3:0] a,
   input  logic [3:0] b,
   input  logic       cin,
   input  logic       pad,
   output logic [3:0] sum,
   output logic       cout
);

   logic [3:0] g;
   logic [3:0] p;
   logic [3:0] raw;
   logic [4:0] c;
   logic       ovf;

   function automatic logic [3:0] sat4(input logic [3:0] x, input logic ov, input logic neg);
      if (!ov) return x;
      return neg ? SAT_NEG4 : SAT_POS4;
   endfunction

   always_comb begin
      g    = a & b;
      p    = a ^ b;
      c[0] = cin & ~pad;
      c[1] = g[0] | (p[0] & c[0]);
      c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
      c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c[0]);
      c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
           | (p[3] & p[2] & p[1] & p[0] & c[0]);
      raw  = p ^ c[3:0];
      // Signed overflow: carry into the sign bit differs from carry out of it.
      ovf  = c[4] ^ c[3];
      sum  = pad ? sat4(raw, ovf, a[3]) : raw;
      cout = c[4];
   end

endmodule

// File: rtl/add_pipe_16.sv
// Two-stage 16-bit ADD/SUB/PADDSB pipeline with valid/ready handshake.
// Define ADD_PIPE_FLAGS_EN to build the registered N/Z/V flag outputs.
module add_pipe_16
   import alu_pkg::*;
#(
   parameter bit SAT_EN = 1'b1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [1:0]  op,
   input  logic [15:0] a,
   input  logic [15:0] b,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [15:0] result,
   output logic        flag_n,
   output logic        flag_z,
   output logic        flag_v
);

   function automatic logic signed [15:0] sat16(input logic signed [15:0] x, input logic ov,
                                                input logic neg);
      if (!(SAT_EN && ov)) return x;
      return neg ? SAT_NEG16 : SAT_POS16;
   endfunction

   logic               is_sub;
   logic               is_pad;
   logic signed [15:0] b_eff;
   logic [7:0]         lo_sum;
   logic               c4;
   logic               c8;

   logic               vld_p1_q, vld_p1_d;
   logic               pad_p1_q, pad_p1_d;
   logic               c8_p1_q, c8_p1_d;
   logic [7:0]         lo_p1_q, lo_p1_d;
   logic signed [7:0]  a_hi_p1_q, a_hi_p1_d;
   logic signed [7:0]  b_hi_p1_q, b_hi_p1_d;

   logic [7:0]         hi_sum;
   logic               c12;
   logic               c16;
   logic signed [15:0] raw_p2;
   logic signed [15:0] res_p2;
   logic               v_p2;

   logic               vld_p2_q, vld_p2_d;
   logic signed [15:0] result_q, result_d;
   logic               s2_adv;
   logic               s2_load;

   // ---- stage 1: low byte, carry into bit 8 registered ----
   always_comb begin
      is_sub = (op == OP_SUB);
      is_pad = (op == OP_PADDSB);
      b_eff  = is_sub ? ~b : b;
   end

   carry_look_ahead u_nib0 (
      .a    (a[3:0]),
      .b    (b_eff[3:0]),
      .cin  (is_sub),
      .pad  (is_pad),
      .sum  (lo_sum[3:0]),
      .cout (c4)
   );

   carry_look_ahead u_nib1 (
      .a    (a[7:4]),
      .b    (b_eff[7:4]),
      .cin  (c4),
      .pad  (is_pad),
      .sum  (lo_sum[7:4]),
      .cout (c8)
   );

   // ---- stage 2: high byte, overflow and saturation ----
   carry_look_ahead u_nib2 (
      .a    (a_hi_p1_q[3:0]),
      .b    (b_hi_p1_q[3:0]),
      .cin  (c8_p1_q),
      .pad  (pad_p1_q),
      .sum  (hi_sum[3:0]),
      .cout (c12)
   );

   carry_look_ahead u_nib3 (
      .a    (a_hi_p1_q[7:4]),
      .b    (b_hi_p1_q[7:4]),
      .cin  (c12),
      .pad  (pad_p1_q),
      .sum  (hi_sum[7:4]),
      .cout (c16)
   );

   always_comb begin
      raw_p2 = {hi_sum, lo_p1_q};
      // Carry into bit 15 is recovered from the sum bit; differs from c16 on overflow.
      v_p2   = ~pad_p1_q & (c16 ^ hi_sum[7] ^ a_hi_p1_q[7] ^ b_hi_p1_q[7]);
      res_p2 = pad_p1_q ? raw_p2 : sat16(raw_p2, v_p2, a_hi_p1_q[7]);
   end

   always_comb begin
      s2_adv    = ~vld_p2_q | out_ready;
      in_ready  = ~vld_p1_q | s2_adv;
      s2_load   = s2_adv & vld_p1_q;

      vld_p1_d  = vld_p1_q;
      pad_p1_d  = pad_p1_q;
      c8_p1_d   = c8_p1_q;
      lo_p1_d   = lo_p1_q;
      a_hi_p1_d = a_hi_p1_q;
      b_hi_p1_d = b_hi_p1_q;
      if (in_ready) begin
         vld_p1_d  = in_valid;
         pad_p1_d  = is_pad;
         c8_p1_d   = c8;
         lo_p1_d   = lo_sum;
         a_hi_p1_d = a[15:8];
         b_hi_p1_d = b_eff[15:8];
      end

      vld_p2_d = vld_p2_q;
      result_d = result_q;
      if (s2_adv) vld_p2_d = vld_p1_q;
      if (s2_load) result_d = res_p2;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         vld_p1_q <= 1'b0;
         vld_p2_q <= 1'b0;
         result_q <= '0;
      end else begin
         vld_p1_q <= vld_p1_d;
         vld_p2_q <= vld_p2_d;
         result_q <= result_d;
      end
   end

   always_ff @(posedge clk) begin
      pad_p1_q  <= pad_p1_d;
      c8_p1_q   <= c8_p1_d;
      lo_p1_q   <= lo_p1_d;
      a_hi_p1_q <= a_hi_p1_d;
      b_hi_p1_q <= b_hi_p1_d;
   end

   assign out_valid = vld_p2_q;
   assign result    = result_q;

`ifdef ADD_PIPE_FLAGS_EN
   logic flag_n_q, flag_n_d;
   logic flag_z_q, flag_z_d;
   logic flag_v_q, flag_v_d;

   // PADDSB refreshes Z only; N and V keep the last ADD/SUB values.
   always_comb begin
      flag_n_d = flag_n_q;
      flag_z_d = flag_z_q;
      flag_v_d = flag_v_q;
      if (s2_load) begin
         flag_z_d = (res_p2 == '0);
         if (!pad_p1_q) begin
            flag_n_d = res_p2[15];
            flag_v_d = v_p2;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         flag_n_q <= 1'b0;
         flag_z_q <= 1'b0;
         flag_v_q <= 1'b0;
      end else begin
         flag_n_q <= flag_n_d;
         flag_z_q <= flag_z_d;
         flag_v_q <= flag_v_d;
      end
   end

   assign flag_n = flag_n_q;
   assign flag_z = flag_z_q;
   assign flag_v = flag_v_q;
`else
   assign flag_n = 1'b0;
   assign flag_z = 1'b0;
   assign flag_v = 1'b0;
`endif

endmodule

// File: doc/add_pipe_16.md
ADD_PIPE_16 -- requirements
Module: add_pipe_16

Interface
REQ-001 SHALL have parameter SAT_EN, default 1: 1 = ADD/SUB saturate to signed 16-bit limits; 0 = ADD/SUB wrap.
REQ-002 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port in_valid  input  1  operand set present.
REQ-005 SHALL have port in_ready  output  1  block accepts an operand set this cycle.
REQ-006 SHALL have port op  input  2  00 ADD, 01 SUB (a-b), 10 PADDSB, 11 reserved (treated as ADD).
REQ-007 SHALL have port a  input  16  first operand.
REQ-008 SHALL have port b  input  16  second operand.
REQ-009 SHALL have port out_valid  output  1  result present.
REQ-010 SHALL have port out_ready  input  1  consumer takes the result.
REQ-011 SHALL have port result  output  16  sum, difference or packed nibble sums.
REQ-012 SHALL have port flag_n, flag_z, flag_v  output  1 each  registered negative, zero, overflow flags.

Function
REQ-013 SHALL be a two-stage pipeline: S1 computes bits [7:0] and registers the carry into bit 8; S2 computes bits [15:8] and applies saturation.
REQ-014 SHALL accept on in_valid & in_ready; result SHALL appear with out_valid exactly 2 cycles after acceptance when not stalled.
REQ-015 SHALL assert in_ready = ~s1_valid | s2_adv, where s2_adv = ~s2_valid | out_ready; no bubbles at full throughput (one op per cycle).
REQ-016 SHALL hold result, out_valid and S1 contents stable while out_valid & ~out_ready.
REQ-017 SHALL compute SUB as a + ~b with carry-in 1 to bit 0.
REQ-018 ADD/SUB overflow SHALL be: operand signs (b inverted for SUB) equal and sum bit 15 differs; with SAT_EN=1, result = 0x7FFF on positive overflow, 0x8000 on negative overflow.
REQ-019 PADDSB SHALL add four independent signed nibbles with no inter-nibble carry, each saturating to 0x7 / 0x8 on overflow.
REQ-020 On each S2 load, flags SHALL update: Z = (result == 0) for all ops; N = result[15] and V = overflow for ADD/SUB; N and V held for PADDSB.
REQ-021 Reserved op 11 SHALL behave identically to ADD, including flags.

Reset
REQ-022 With rst_n low at a rising edge: s1_valid, out_valid, result, flag_n, flag_z, flag_v SHALL be 0 on the following cycle, in_ready SHALL be 1.
REQ-023 Reset mid-operation SHALL discard in-flight ops; no partial result SHALL be emitted afterwards.

Configuration
REQ-024 Macro ADD_PIPE_FLAGS_EN defined: flag register per REQ-020 is present.
REQ-025 Macro undefined: flag register SHALL be omitted, flag_n/flag_z/flag_v tied 0; datapath and timing unchanged.

Structure
REQ-026 Op encodings (ADD, SUB, PADDSB), SAT_POS16 = 0x7FFF, SAT_NEG16 = 0x8000, SAT_POS4 = 0x7, SAT_NEG4 = 0x8 SHALL live in shared package alu_pkg.
REQ-027 Nibble arithmetic SHALL use the existing 4-bit carry_look_ahead slice, four instances (two per stage), pad driven by op == PADDSB.

Verification
REQ-028 ADD a=0x7FFF b=0x0001 -> result 0x7FFF, V=1 N=0 Z=0, out_valid exactly 2 cycles after accept.
REQ-029 SUB a=0x8000 b=0x0001 -> result 0x8000, V=1 N=1 Z=0; with SAT_EN=0 -> 0x7FFF, V=1.
REQ-030 PADDSB a=0x7F12 b=0x1F11 -> result 0x7E23; N/V unchanged from previous op, Z=0.
REQ-031 ADD a=0x0005 b=0xFFFB -> result 0x0000, Z=1 N=0 V=0.
REQ-032 Back-to-back 4 ops with out_ready=0 for 3 cycles -> 2 ops held, in_ready low, no loss or reordering when out_ready returns.
REQ-033 rst_n low for one cycle with both stages valid -> next cycle out_valid=0, flags 0, in_ready=1, no stale result afterwards.
